// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle MIPS control FSM with memory-ready handshake and wait timeout.
module mc_ctrl_unit #(
  parameter int ALUOP_W = 2,
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic [5:0]         i_instr_code,
  input  logic               i_mem_ready,
  output logic [3:0]         o_state,
  output logic               o_pc_wr,
  output logic               o_pc_wr_beq,
  output logic               o_pc_wr_bne,
  output logic [1:0]         o_pc_src,
  output logic               o_iord,
  output logic               o_mem_rd,
  output logic               o_mem_wr,
  output logic               o_ir_wr,
  output logic               o_reg_dst,
  output logic               o_mem_reg,
  output logic               o_reg_wr,
  output logic               o_extend,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic               o_instr_done,
  output logic               o_fault
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
    MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7, RWB = 4'd8, IEXEC = 4'd9,
    IWB = 4'd10, BRANCH = 4'd11, JUMP = 4'd12, FAULT = 4'd13
  } state_t;
  localparam logic [5:0] RTYP = 6'b000000, ADDIU = 6'b001001, SOLT = 6'b101010,
    BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010, LW = 6'b100011, SW = 6'b101011;
  state_t state, nxt, done_nxt;
  logic [WAIT_W-1:0] cnt;
  logic [1:0] alu_op;
  logic waiting, tmo;
  assign waiting = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  // cnt holds the number of not-ready cycles already spent in this wait state
  assign tmo = (TIMEOUT != 0) && !i_mem_ready && (cnt == WAIT_W'(TIMEOUT - 1));
  assign done_nxt = i_run ? FETCH : IDLE;
  assign o_state = state;
  assign o_alu_op = ALUOP_W'(alu_op);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (waiting && !i_mem_ready) ? cnt + WAIT_W'(1) : '0;
    end
  always_comb begin
    nxt = state;
    o_pc_wr = 1'b0;
    o_pc_wr_beq = 1'b0;
    o_pc_wr_bne = 1'b0;
    o_pc_src = 2'b00;
    o_iord = 1'b0;
    o_mem_rd = 1'b0;
    o_mem_wr = 1'b0;
    o_ir_wr = 1'b0;
    o_reg_dst = 1'b0;
    o_mem_reg = 1'b0;
    o_reg_wr = 1'b0;
    o_extend = 1'b0;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 2'b00;
    alu_op = 2'b00;
    o_instr_done = 1'b0;
    o_fault = 1'b0;
    case (state)
      IDLE: nxt = i_run ? FETCH : IDLE;
      FETCH: begin
        o_mem_rd = 1'b1;
        o_alu_src_b = 2'b01;
        o_ir_wr = i_mem_ready;
        o_pc_wr = i_mem_ready;
        nxt = i_mem_ready ? DECODE : (tmo ? FAULT : FETCH);
      end
      DECODE: begin
        o_alu_src_b = 2'b11;
        o_extend = 1'b1;
        nxt = (i_instr_code == RTYP) ? EXEC :
              (i_instr_code == ADDIU || i_instr_code == SOLT) ? IEXEC :
              (i_instr_code == LW || i_instr_code == SW) ? MEMADR :
              (i_instr_code == BEQ || i_instr_code == BNE) ? BRANCH :
              (i_instr_code == J) ? JUMP : FAULT;
      end
      EXEC: begin
        o_alu_src_a = 1'b1;
        alu_op = 2'b10;
        nxt = RWB;
      end
      RWB: begin
        o_reg_dst = 1'b1;
        o_reg_wr = 1'b1;
        o_instr_done = 1'b1;
        nxt = done_nxt;
      end
      IEXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        alu_op = 2'b11;
        nxt = IWB;
      end
      IWB: begin
        o_reg_wr = 1'b1;
        o_instr_done = 1'b1;
        nxt = done_nxt;
      end
      MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_extend = 1'b1;
        alu_op = 2'b11;
        nxt = (i_instr_code == LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        o_mem_rd = 1'b1;
        o_iord = 1'b1;
        nxt = i_mem_ready ? MEMWB : (tmo ? FAULT : MEMRD);
      end
      MEMWB: begin
        o_mem_reg = 1'b1;
        o_reg_wr = 1'b1;
        o_instr_done = 1'b1;
        nxt = done_nxt;
      end
      MEMWR: begin
        o_mem_wr = 1'b1;
        o_iord = 1'b1;
        o_instr_done = i_mem_ready;
        nxt = i_mem_ready ? done_nxt : (tmo ? FAULT : MEMWR);
      end
      BRANCH: begin
        o_alu_src_a = 1'b1;
        alu_op = 2'b01;
        o_pc_src = 2'b01;
        o_pc_wr_beq = (i_instr_code == BEQ);
        o_pc_wr_bne = (i_instr_code == BNE);
        o_instr_done = 1'b1;
        nxt = done_nxt;
      end
      JUMP: begin
        o_pc_wr = 1'b1;
        o_pc_src = 2'b10;
        o_instr_done = 1'b1;
        nxt = done_nxt;
      end
      FAULT: o_fault = 1'b1;
      default: nxt = FAULT;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: directed per-cycle expectations queued by stimulus, checked by a negedge monitor.
module tb_mc_ctrl_unit;
  localparam logic [5:0] RTYP = 6'b000000, ADDIU = 6'b001001, BEQ = 6'b000100,
    BNE = 6'b000101, J = 6'b000010, LW = 6'b100011, SW = 6'b101011, BAD = 6'b111111;
  logic clk, rst_n, run, mem_ready;
  logic [5:0] instr_code;
  logic [3:0] state;
  logic pc_wr, pc_wr_beq, pc_wr_bne, iord, mem_rd, mem_wr, ir_wr;
  logic reg_dst, mem_reg, reg_wr, extend, alu_src_a, instr_done, fault;
  logic [1:0] pc_src, alu_src_b, alu_op;
  typedef struct {string nm; logic [23:0] v;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  mc_ctrl_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_instr_code(instr_code),
    .i_mem_ready(mem_ready), .o_state(state), .o_pc_wr(pc_wr), .o_pc_wr_beq(pc_wr_beq),
    .o_pc_wr_bne(pc_wr_bne), .o_pc_src(pc_src), .o_iord(iord), .o_mem_rd(mem_rd),
    .o_mem_wr(mem_wr), .o_ir_wr(ir_wr), .o_reg_dst(reg_dst), .o_mem_reg(mem_reg),
    .o_reg_wr(reg_wr), .o_extend(extend), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
    .o_alu_op(alu_op), .o_instr_done(instr_done), .o_fault(fault)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [23:0] ev(logic [3:0] s, logic [5:0] op, logic rdy);
    logic pw, beq, bne, io, mrd, mwr, irw, rd, mr, rw, ext, sa, dn, flt;
    logic [1:0] ps, sb, ao;
    {pw, beq, bne, io, mrd, mwr, irw, rd, mr, rw, ext, sa, dn, flt} = '0;
    {ps, sb, ao} = '0;
    case (s)
      4'd1: begin mrd = 1; sb = 2'b01; pw = rdy; irw = rdy; end
      4'd2: begin sb = 2'b11; ext = 1; end
      4'd3: begin sa = 1; sb = 2'b10; ext = 1; ao = 2'b11; end
      4'd4: begin mrd = 1; io = 1; end
      4'd5: begin mr = 1; rw = 1; dn = 1; end
      4'd6: begin mwr = 1; io = 1; dn = rdy; end
      4'd7: begin sa = 1; ao = 2'b10; end
      4'd8: begin rd = 1; rw = 1; dn = 1; end
      4'd9: begin sa = 1; sb = 2'b10; ao = 2'b11; end
      4'd10: begin rw = 1; dn = 1; end
      4'd11: begin sa = 1; ao = 2'b01; ps = 2'b01; beq = (op == BEQ); bne = (op == BNE); dn = 1; end
      4'd12: begin pw = 1; ps = 2'b10; dn = 1; end
      4'd13: flt = 1;
      default: ;
    endcase
    return {s, pw, beq, bne, ps, io, mrd, mwr, irw, rd, mr, rw, ext, sa, sb, ao, dn, flt};
  endfunction
  function automatic logic [23:0] act_v();
    return {state, pc_wr, pc_wr_beq, pc_wr_bne, pc_src, iord, mem_rd, mem_wr, ir_wr,
            reg_dst, mem_reg, reg_wr, extend, alu_src_a, alu_src_b, alu_op, instr_done, fault};
  endfunction
  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (direct): got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic step(input string nm, input logic [3:0] s, input logic [5:0] op,
                      input logic rdy, input logic r);
    instr_code = op;
    mem_ready = rdy;
    run = r;
    q.push_back('{nm, ev(s, op, rdy)});
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    chk({nm, "_async"}, act_v(), ev(4'd0, RTYP, 1'b0));
    q.push_back('{nm, ev(4'd0, RTYP, 1'b0)});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act_v() !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, act_v(), e.v);
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    instr_code = RTYP;
    @(posedge clk);
    #1;
    do_reset("reset");
    step("idle", 4'd0, RTYP, 1, 1);
    step("r_fetch", 4'd1, RTYP, 1, 1);
    step("r_decode", 4'd2, RTYP, 1, 1);
    step("r_exec", 4'd7, RTYP, 1, 1);
    step("r_wb", 4'd8, RTYP, 1, 1);
    step("lw_fetch", 4'd1, LW, 1, 1);
    step("lw_decode", 4'd2, LW, 1, 1);
    step("lw_adr", 4'd3, LW, 1, 1);
    repeat (3) step("lw_wait", 4'd4, LW, 0, 1);
    step("lw_rd", 4'd4, LW, 1, 1);
    step("lw_wb", 4'd5, LW, 1, 1);
    step("sw_fetch", 4'd1, SW, 1, 1);
    step("sw_decode", 4'd2, SW, 1, 1);
    step("sw_adr", 4'd3, SW, 1, 1);
    step("sw_wait", 4'd6, SW, 0, 1);
    step("sw_wr", 4'd6, SW, 1, 1);
    step("addiu_fetch", 4'd1, ADDIU, 1, 1);
    step("addiu_decode", 4'd2, ADDIU, 1, 1);
    step("addiu_exec", 4'd9, ADDIU, 1, 1);
    step("addiu_wb", 4'd10, ADDIU, 1, 1);
    step("beq_fetch", 4'd1, BEQ, 1, 1);
    step("beq_decode", 4'd2, BEQ, 1, 1);
    step("beq_branch", 4'd11, BEQ, 1, 1);
    step("bne_fetch", 4'd1, BNE, 1, 1);
    step("bne_decode", 4'd2, BNE, 1, 1);
    step("bne_branch", 4'd11, BNE, 1, 1);
    step("j_fetch", 4'd1, J, 1, 0);
    step("j_decode", 4'd2, J, 1, 0);
    step("j_jump", 4'd12, J, 1, 0);
    step("j_idle", 4'd0, J, 1, 0);
    step("to_fetch", 4'd0, RTYP, 1, 1);
    repeat (14) step("fetch_wait", 4'd1, RTYP, 0, 1);
    step("fetch_ready_last", 4'd1, RTYP, 1, 1);
    step("late_decode", 4'd2, RTYP, 1, 1);
    step("late_exec", 4'd7, RTYP, 1, 1);
    step("late_wb", 4'd8, RTYP, 1, 1);
    step("sw2_fetch", 4'd1, SW, 1, 1);
    step("sw2_decode", 4'd2, SW, 1, 1);
    step("sw2_adr", 4'd3, SW, 1, 1);
    step("sw2_wait", 4'd6, SW, 0, 1);
    do_reset("async_reset_mid_write");
    step("post_reset_idle", 4'd0, RTYP, 0, 1);
    repeat (15) step("fetch_stuck", 4'd1, RTYP, 0, 1);
    step("fault_a", 4'd13, RTYP, 0, 1);
    chk("expired_wait_fault", act_v(), ev(4'd13, RTYP, 1'b0));
    step("fault_b", 4'd13, RTYP, 1, 0);
    step("fault_c", 4'd13, RTYP, 1, 1);
    do_reset("reset2");
    step("bad_idle", 4'd0, BAD, 1, 1);
    step("bad_fetch", 4'd1, BAD, 1, 1);
    step("bad_decode", 4'd2, BAD, 1, 0);
    step("bad_fault_a", 4'd13, BAD, 1, 1);
    step("bad_fault_b", 4'd13, BAD, 0, 0);
    step("bad_fault_c", 4'd13, BAD, 1, 1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_unit.md
Name: mc_ctrl_unit

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the shared-memory multicycle datapath.
- Handshakes with a variable-latency memory through a ready signal, with a parametrised wait timeout.
- Sits between the instruction register and the datapath muxes, register file and memory interface.

Parameters:
ALUOP_W, 2, width of o_alu_op. Codes: 00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded immediate. Upper bits zero-filled when ALUOP_W > 2.
WAIT_W, 4, width of the memory-wait counter.
TIMEOUT, 15, consecutive not-ready cycles tolerated in a wait state. 0 disables the timeout. Must be < 2^WAIT_W.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_run  in  1  start/continue execution; sampled at instruction boundaries
i_instr_code  in  6  opcode from the instruction register
i_mem_ready  in  1  memory completed the current read or write this cycle
o_state  out  4  current state encoding, for debug
o_pc_wr, o_pc_wr_beq, o_pc_wr_bne  out  1 each  PC write: unconditional / if zero / if not zero
o_pc_src  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
o_iord  out  1  memory address source: 0 PC, 1 ALUOut
o_mem_rd, o_mem_wr  out  1 each  memory read/write request
o_ir_wr  out  1  instruction register load
o_reg_dst, o_mem_reg, o_reg_wr, o_extend  out  1 each  same meaning as the single-cycle unit (o_extend: 1 sign-extend, 0 zero-extend)
o_alu_src_a  out  1  ALU A input: 0 PC, 1 rs
o_alu_src_b  out  2  ALU B input: 00 rt, 01 constant 4, 10 extended immediate, 11 extended immediate shifted left by 2
o_alu_op  out  ALUOP_W  ALU operation class
o_instr_done  out  1  one-cycle pulse in an instruction's final cycle
o_fault  out  1  sticky fault flag

Behaviour:
- Opcodes: RTYP 000000, ADDIU 001001, SOLT 101010, BEQ 000100, BNE 000101, J 000010, LW 100011, SW 101011.
- States: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, IEXEC 9, IWB 10, BRANCH 11, JUMP 12, FAULT 13.
- Reset (asynchronous): state goes to IDLE, wait counter clears, every output is 0. Reset mid-instruction abandons it with no further writes.
- Outputs are Moore per state; any output not listed for a state is 0. Exception: o_ir_wr and o_pc_wr in FETCH are also gated by i_mem_ready.
- IDLE: all outputs 0. Go to FETCH when i_run=1.
- FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - While i_mem_ready=1: ir_wr=1 and pc_wr=1, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, extend=1, alu_op=00 (branch target into ALUOut). Next state:
  - RTYP -> EXEC
  - ADDIU or SOLT -> IEXEC
  - LW or SW -> MEMADR
  - BEQ or BNE -> BRANCH
  - J -> JUMP
  - any other opcode -> FAULT
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB.
- RWB: reg_dst=1, reg_wr=1, instr_done=1.
- IEXEC: alu_src_a=1, alu_src_b=10, extend=0, alu_op=11 -> IWB.
- IWB: reg_dst=0, reg_wr=1, instr_done=1.
- MEMADR: alu_src_a=1, alu_src_b=10, extend=1, alu_op=11 -> MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_rd=1, iord=1. Hold until ready, then go to MEMWB.
- MEMWB: mem_reg=1, reg_wr=1, instr_done=1.
- MEMWR: mem_wr=1, iord=1, held until ready. instr_done=1 in the cycle ready=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. pc_wr_beq=1 for BEQ, pc_wr_bne=1 for BNE. The branch opcode is sampled from i_instr_code, which the IR holds stable. instr_done=1.
- JUMP: pc_wr=1, pc_src=10, instr_done=1.
- Every instr_done state goes to FETCH if i_run=1, else to IDLE.
- Latency with zero memory wait: J/BEQ/BNE 3 cycles; RTYP/ADDIU/SOLT/SW 4; LW 5. Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle in those states while i_mem_ready=0.
  - When TIMEOUT≠0 and ready has been low for TIMEOUT consecutive cycles in one wait state, go to FAULT at that cycle's edge.
  - If ready=1 arrives in the TIMEOUT-th cycle, ready wins and there is no fault.
- FAULT: o_fault=1, all other outputs 0. Left only by reset; i_run is ignored.
- i_run deasserted mid-instruction has no effect until the instruction boundary.

Test Plan:
- Reset, i_run=1, RTYP, ready always 1 -> states 1,2,7,8,1. ir_wr and pc_wr high in cycle 1. reg_wr=1, reg_dst=1, instr_done=1 in cycle 4.
- LW with ready low for 3 cycles in MEMRD -> LW completes in 8 cycles; mem_rd and iord held high through the wait; no fault.
- TIMEOUT=15, ready stuck 0 in FETCH -> FAULT after 15 cycles with o_fault=1. Ready=1 on the 15th cycle instead -> DECODE.
- Opcode 111111 in DECODE -> FAULT; outputs all 0 except o_fault; state stays 13 despite i_run toggling.
- BNE then J, i_run dropped during J -> BNE: pc_wr_bne=1 only, pc_src=01. J: pc_wr=1, pc_src=10. Then state 0 and outputs 0.
- i_rst_n pulled low mid-MEMWR -> mem_wr drops immediately (asynchronously); after release, state=IDLE.
